pipeline_hazard_tracker: RTL and testbench

- Producer side of the forwarding interface: a three-stage in-flight destination tracker.
- Registers each decoded instruction's destination register and write flags through the ID/EX, EX/MEM and MEM/WB slots.
- Drives the ID_EX/EX_MEM/MEM_WB rd and regwrite buses consumed by forwarding_unit.
- Detects load-use hazards against the IF/ID source registers and generates stall and bubble control. Also handles branch flush and debug single-step gating.

---
 rtl/pipeline_hazard_tracker.sv | 96 +++++++++
 tb/tb_pipeline_hazard_tracker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_tracker.sv
// In-flight destination tracker for the ID/EX, EX/MEM and MEM/WB slots.
// Feeds the forwarding unit and raises load-use stall, bubble and IF/ID flush control.
module pipeline_hazard_tracker #(
   parameter int RBITS = 5,
   parameter int SBITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [RBITS-1:0] IF_ID_rs,
   input  logic [RBITS-1:0] IF_ID_rt,
   input  logic [RBITS-1:0] dec_rd,
   input  logic             dec_regwrite,
   input  logic             dec_memread,
   input  logic             branch_taken,
   output logic [RBITS-1:0] ID_EX_rd,
   output logic [RBITS-1:0] EX_MEM_rd,
   output logic [RBITS-1:0] MEM_WB_rd,
   output logic             ID_EX_regwrite,
   output logic             EX_MEM_regwrite,
   output logic             MEM_WB_regwrite,
   output logic             stall,
   output logic             if_id_flush,
   output logic [SBITS-1:0] stall_cycles
);

   localparam logic [SBITS-1:0] MAX_STALL = SBITS'(2);

   // Slot 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
   logic [RBITS-1:0] rd_reg [3];
   logic [2:0]       regwrite_reg;
   // MEM/WB needs no load flag: its data is already forwardable.
   logic [1:0]       memread_reg;
   logic [SBITS-1:0] stall_cycles_reg;

   logic [1:0]       hz;
   logic             stall_int;
   logic             bubble;
   logic             entry_regwrite;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_hz
         assign hz[gi] = memread_reg[gi] & regwrite_reg[gi] & (rd_reg[gi] != '0) &
                         ((rd_reg[gi] == IF_ID_rs) | (rd_reg[gi] == IF_ID_rt));
      end
   endgenerate

   assign stall_int      = (|hz) & enable & ~reset;
   assign bubble         = stall_int | branch_taken;
   // A write to r0 is architecturally a no-op, so it never looks like a producer.
   assign entry_regwrite = dec_regwrite & (dec_rd != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            rd_reg[i] <= '0;
         end
         regwrite_reg     <= '0;
         memread_reg      <= '0;
         stall_cycles_reg <= '0;
      end else if (enable) begin
         rd_reg[2]       <= rd_reg[1];
         regwrite_reg[2] <= regwrite_reg[1];
         rd_reg[1]       <= rd_reg[0];
         regwrite_reg[1] <= regwrite_reg[0];
         memread_reg[1]  <= memread_reg[0];
         if (bubble) begin
            rd_reg[0]       <= '0;
            regwrite_reg[0] <= 1'b0;
            memread_reg[0]  <= 1'b0;
         end else begin
            rd_reg[0]       <= entry_regwrite ? dec_rd : '0;
            regwrite_reg[0] <= entry_regwrite;
            memread_reg[0]  <= dec_memread;
         end
         if (!stall_int) begin
            stall_cycles_reg <= '0;
         end else if (stall_cycles_reg != MAX_STALL) begin
            stall_cycles_reg <= stall_cycles_reg + SBITS'(1);
         end
      end
   end

   assign ID_EX_rd        = rd_reg[0];
   assign EX_MEM_rd       = rd_reg[1];
   assign MEM_WB_rd       = rd_reg[2];
   assign ID_EX_regwrite  = regwrite_reg[0];
   assign EX_MEM_regwrite = regwrite_reg[1];
   assign MEM_WB_regwrite = regwrite_reg[2];
   assign stall           = stall_int;
   // A pending stall holds the branch in decode; it is flushed once the hazard clears.
   assign if_id_flush     = branch_taken & ~stall_int & enable & ~reset;
   assign stall_cycles    = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// Directed vector bench for pipeline_hazard_tracker: one row per clock cycle,
// stall/flush sampled before the edge, slot outputs and stall_cycles after it.
module tb_pipeline_hazard_tracker;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [4:0] IF_ID_rs, IF_ID_rt, dec_rd;
   logic       dec_regwrite, dec_memread, branch_taken;
   logic [4:0] ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
   logic       ID_EX_regwrite, EX_MEM_regwrite, MEM_WB_regwrite;
   logic       stall, if_id_flush;
   logic [1:0] stall_cycles;

   pipeline_hazard_tracker #(.RBITS(5), .SBITS(2)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .dec_rd(dec_rd),
      .dec_regwrite(dec_regwrite), .dec_memread(dec_memread), .branch_taken(branch_taken),
      .ID_EX_rd(ID_EX_rd), .EX_MEM_rd(EX_MEM_rd), .MEM_WB_rd(MEM_WB_rd),
      .ID_EX_regwrite(ID_EX_regwrite), .EX_MEM_regwrite(EX_MEM_regwrite),
      .MEM_WB_regwrite(MEM_WB_regwrite),
      .stall(stall), .if_id_flush(if_id_flush), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en;
      logic [4:0] rs, rt, rd;
      logic       rw, mr, br;
      logic       e_stall, e_flush;
      logic [4:0] e_idex_rd, e_exmem_rd, e_memwb_rd;
      logic       e_idex_rw, e_exmem_rw, e_memwb_rw;
      logic [1:0] e_scyc;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input logic rst, input logic en, input int rs, input int rt,
                      input int rd, input logic rw, input logic mr, input logic br,
                      input logic es, input logic ef,
                      input int r0, input logic w0, input int r1, input logic w1,
                      input int r2, input logic w2, input int sc);
      vec_t v;
      v.rst = rst; v.en = en; v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
      v.rw = rw; v.mr = mr; v.br = br; v.e_stall = es; v.e_flush = ef;
      v.e_idex_rd = 5'(r0); v.e_idex_rw = w0;
      v.e_exmem_rd = 5'(r1); v.e_exmem_rw = w1;
      v.e_memwb_rd = 5'(r2); v.e_memwb_rw = w2;
      v.e_scyc = 2'(sc);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; IF_ID_rs = 5'd7; IF_ID_rt = 5'd7; dec_rd = 5'd7;
      dec_regwrite = 1'b1; dec_memread = 1'b0; branch_taken = 1'b0;

      //   rst en rs rt rd rw mr br | stall flush | idex    exmem   memwb  | scyc
      add(1, 1, 7, 7, 7, 1, 0, 0,   0, 0,   0, 0,   0, 0,   0, 0,   0);  // reset
      add(0, 1, 0, 0, 2, 1, 0, 0,   0, 0,   2, 1,   0, 0,   0, 0,   0);  // ALU stream
      add(0, 1, 0, 0, 3, 1, 0, 0,   0, 0,   3, 1,   2, 1,   0, 0,   0);
      add(0, 1, 0, 0, 4, 1, 0, 0,   0, 0,   4, 1,   3, 1,   2, 1,   0);
      add(0, 1, 9, 9, 2, 1, 1, 0,   0, 0,   2, 1,   4, 1,   3, 1,   0);  // load r2
      add(0, 1, 2, 0, 6, 1, 0, 0,   1, 0,   0, 0,   2, 1,   4, 1,   1);  // dependent
      add(0, 1, 2, 0, 6, 1, 0, 0,   1, 0,   0, 0,   0, 0,   2, 1,   2);
      add(0, 1, 2, 0, 6, 1, 0, 0,   0, 0,   6, 1,   0, 0,   0, 0,   0);
      add(0, 1, 0, 0, 2, 1, 1, 0,   0, 0,   2, 1,   6, 1,   0, 0,   0);  // load r2
      add(0, 1, 0, 5, 7, 1, 0, 0,   0, 0,   7, 1,   2, 1,   6, 1,   0);  // independent
      add(0, 1, 0, 2, 8, 1, 0, 0,   1, 0,   0, 0,   7, 1,   2, 1,   1);  // rt=2
      add(0, 1, 0, 2, 8, 1, 0, 0,   0, 0,   8, 1,   0, 0,   7, 1,   0);
      add(0, 1, 0, 0, 0, 1, 1, 0,   0, 0,   0, 0,   8, 1,   0, 0,   0);  // load r0
      add(0, 1, 0, 0, 9, 0, 0, 0,   0, 0,   0, 0,   0, 0,   8, 1,   0);
      add(0, 1, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0,   0, 0,   0, 0,   0);
      add(0, 1, 1, 1, 5, 1, 0, 1,   0, 1,   0, 0,   0, 0,   0, 0,   0);  // branch
      add(0, 1, 0, 0, 4, 1, 1, 0,   0, 0,   4, 1,   0, 0,   0, 0,   0);  // load r4
      add(0, 1, 4, 0,10, 1, 0, 1,   1, 0,   0, 0,   4, 1,   0, 0,   1);  // branch in stall
      add(0, 1, 4, 0,10, 1, 0, 1,   1, 0,   0, 0,   0, 0,   4, 1,   2);
      add(0, 1, 4, 0,10, 1, 0, 1,   0, 1,   0, 0,   0, 0,   0, 0,   0);
      add(0, 1, 0, 0, 5, 1, 1, 0,   0, 0,   5, 1,   0, 0,   0, 0,   0);  // load r5
      add(0, 1, 5, 0,11, 1, 0, 0,   1, 0,   0, 0,   5, 1,   0, 0,   1);
      add(0, 0, 5, 0,11, 1, 0, 0,   0, 0,   0, 0,   5, 1,   0, 0,   1);  // frozen
      add(0, 0, 5, 0,11, 1, 0, 1,   0, 0,   0, 0,   5, 1,   0, 0,   1);
      add(0, 0, 5, 0,11, 1, 0, 0,   0, 0,   0, 0,   5, 1,   0, 0,   1);
      add(0, 1, 5, 0,11, 1, 0, 0,   1, 0,   0, 0,   0, 0,   5, 1,   2);  // resumes
      add(0, 1, 5, 0,11, 1, 0, 0,   0, 0,  11, 1,   0, 0,   0, 0,   0);
      add(0, 1, 0, 0, 6, 1, 1, 0,   0, 0,   6, 1,  11, 1,   0, 0,   0);  // load r6
      add(0, 1, 6, 0,12, 1, 0, 0,   1, 0,   0, 0,   6, 1,  11, 1,   1);
      add(1, 1, 6, 0,12, 1, 0, 0,   0, 0,   0, 0,   0, 0,   0, 0,   0);  // reset mid-stall
      add(0, 1, 0, 0, 3, 1, 0, 0,   0, 0,   3, 1,   0, 0,   0, 0,   0);
      add(1, 0, 0, 0, 3, 1, 0, 0,   0, 0,   0, 0,   0, 0,   0, 0,   0);  // reset, en=0
      add(0, 1, 0, 0, 2, 1, 1, 0,   0, 0,   2, 1,   0, 0,   0, 0,   0);  // load r2
      add(0, 1, 0, 0, 3, 1, 1, 0,   0, 0,   3, 1,   2, 1,   0, 0,   0);  // load r3
      add(0, 1, 2, 3,13, 1, 0, 0,   1, 0,   0, 0,   3, 1,   2, 1,   1);  // both hazards
      add(0, 1, 2, 3,13, 1, 0, 0,   1, 0,   0, 0,   0, 0,   3, 1,   2);
      add(0, 1, 2, 3,13, 1, 0, 0,   0, 0,  13, 1,   0, 0,   0, 0,   0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset = vecs[i].rst; enable = vecs[i].en;
         IF_ID_rs = vecs[i].rs; IF_ID_rt = vecs[i].rt; dec_rd = vecs[i].rd;
         dec_regwrite = vecs[i].rw; dec_memread = vecs[i].mr; branch_taken = vecs[i].br;
         #1;
         chk("stall", i, 32'(stall), 32'(vecs[i].e_stall));
         chk("if_id_flush", i, 32'(if_id_flush), 32'(vecs[i].e_flush));
         @(posedge clk);
         #1;
         chk("ID_EX_rd", i, 32'(ID_EX_rd), 32'(vecs[i].e_idex_rd));
         chk("EX_MEM_rd", i, 32'(EX_MEM_rd), 32'(vecs[i].e_exmem_rd));
         chk("MEM_WB_rd", i, 32'(MEM_WB_rd), 32'(vecs[i].e_memwb_rd));
         chk("ID_EX_regwrite", i, 32'(ID_EX_regwrite), 32'(vecs[i].e_idex_rw));
         chk("EX_MEM_regwrite", i, 32'(EX_MEM_regwrite), 32'(vecs[i].e_exmem_rw));
         chk("MEM_WB_regwrite", i, 32'(MEM_WB_regwrite), 32'(vecs[i].e_memwb_rw));
         chk("stall_cycles", i, 32'(stall_cycles), 32'(vecs[i].e_scyc));
         $display("row %0d: rst=%0b en=%0b rs=%0d rt=%0d rd=%0d stall=%0b flush=%0b idex=%0d exmem=%0d memwb=%0d scyc=%0d",
                  i, vecs[i].rst, vecs[i].en, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                  vecs[i].e_stall, vecs[i].e_flush, ID_EX_rd, EX_MEM_rd, MEM_WB_rd, stall_cycles);
      end

      // Hand sequence: stall follows enable combinationally, and a branch waits out the stall.
      @(negedge clk);
      reset = 1'b0; enable = 1'b1; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
      dec_rd = 5'd9; dec_regwrite = 1'b1; dec_memread = 1'b1; branch_taken = 1'b0;
      @(posedge clk);
      #1;
      chk("seq load ID_EX_rd", 100, 32'(ID_EX_rd), 32'd9);
      @(negedge clk);
      enable = 1'b0; IF_ID_rs = 5'd9; dec_rd = 5'd14; dec_memread = 1'b0; branch_taken = 1'b1;
      #1;
      chk("seq stall gated", 101, 32'(stall), 32'd0);
      chk("seq flush gated", 101, 32'(if_id_flush), 32'd0);
      enable = 1'b1;
      #1;
      chk("seq stall live", 102, 32'(stall), 32'd1);
      chk("seq flush held", 102, 32'(if_id_flush), 32'd0);
      @(posedge clk);
      #1;
      chk("seq stall_cycles", 103, 32'(stall_cycles), 32'd1);
      chk("seq bubble", 103, 32'(ID_EX_regwrite), 32'd0);
      $display("seq: load r9 then dependent branch, stall_cycles=%0d", stall_cycles);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
